// File: rtl/rr_arbiter_16_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter:
// state encoding, requester count and owner index width.
package rr_arbiter_16_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_16_decoder.sv
// 4-to-16 one-hot decoder with an enable; the output is all-zero when disabled.
module decoder_4x16 (
  input  logic [3:0]  inputs,
  input  logic        enabled,
  output logic [15:0] outputs
);

  // One-hot decode of the index, gated by enable
  always_comb begin
    outputs = 16'h0000;
    if (enabled) begin
      outputs[inputs] = 1'b1;
    end else begin
      outputs = 16'h0000;
    end
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with a bounded hold time per owner and
// a one-cycle grant latency; grant is decoded from registered state only.
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enabled,
  input  logic [NUM_REQ-1:0] requests,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  localparam logic [IDX_W-1:0] HOLD_LAST = IDX_W'(HOLD_MAX - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_pointer;
  logic [IDX_W-1:0]   r_hold;

  logic [NUM_REQ-1:0] w_cand;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_pos;
  logic               w_valid;

  assign w_valid     = (r_state == ST_GRANT);
  assign grant_valid = w_valid;
  assign grant_idx   = r_idx;

  // Candidate set: the current owner is never its own successor
  always_comb begin
    w_cand = requests;
    if (r_state == ST_GRANT) begin
      w_cand = requests & ~(16'h0001 << r_idx);
    end else begin
      w_cand = requests;
    end
  end

  // Round-robin search starting just after the last owner, wrapping onto it
  always_comb begin
    w_found = 1'b0;
    w_win   = r_pointer;
    w_pos   = r_pointer;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos = r_pointer + IDX_W'(i) + 4'd1;
      if (!w_found && w_cand[w_pos]) begin
        w_found = 1'b1;
        w_win   = w_pos;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Arbitration FSM: owner, last-owner pointer and hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= 4'd0;
      r_pointer <= 4'hF;
      r_hold    <= 4'd0;
    end else if (!enabled) begin
      r_state <= ST_IDLE;
      r_hold  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state   <= ST_GRANT;
            r_idx     <= w_win;
            r_pointer <= w_win;
            r_hold    <= 4'd0;
          end
        end
        ST_GRANT: begin
          if (requests[r_idx]) begin
            if ((r_hold == HOLD_LAST) && w_found) begin
              r_idx     <= w_win;
              r_pointer <= w_win;
              r_hold    <= 4'd0;
            end else if (r_hold != HOLD_LAST) begin
              r_hold <= r_hold + 4'd1;
            end
          end else if (w_found) begin
            // Hand over directly, no idle bubble
            r_idx     <= w_win;
            r_pointer <= w_win;
            r_hold    <= 4'd0;
          end else begin
            r_state <= ST_IDLE;
            r_hold  <= 4'd0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_hold  <= 4'd0;
        end
      endcase
    end
  end

  decoder_4x16 u_decoder (
    .inputs  (r_idx),
    .enabled (w_valid),
    .outputs (grant)
  );

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed scenarios plus random
// traffic, compared against a per-instance behavioural arbitration model.
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enabled = 1'b0;
  logic [15:0] requests = 16'h0000;
  logic [15:0] grant8, grant1;
  logic [3:0]  idx8, idx1;
  logic        valid8, valid1;

  int errors = 0;
  int checks = 0;

  // Model state per instance: 0 -> HOLD_MAX=8, 1 -> HOLD_MAX=1
  int m_owner[2];
  int m_last[2];
  int m_run[2];
  int m_hmax[2] = '{8, 1};

  rr_arbiter_16 #(.HOLD_MAX(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .enabled(enabled), .requests(requests),
    .grant(grant8), .grant_idx(idx8), .grant_valid(valid8)
  );

  rr_arbiter_16 #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enabled(enabled), .requests(requests),
    .grant(grant1), .grant_idx(idx1), .grant_valid(valid1)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [15:0] r, int excl, int last);
    for (int i = 1; i <= 16; i++) begin
      int j;
      j = (last + i) % 16;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_grant(int k);
    logic [15:0] one;
    one = 16'h0001;
    if (m_owner[k] < 0) return 16'h0000;
    return one << m_owner[k];
  endfunction

  function automatic logic [15:0] get_grant(int k);
    return (k == 0) ? grant8 : grant1;
  endfunction

  function automatic logic [3:0] get_idx(int k);
    return (k == 0) ? idx8 : idx1;
  endfunction

  function automatic logic get_valid(int k);
    return (k == 0) ? valid8 : valid1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_last[k]  = 15;
      m_run[k]   = 0;
    end
  endtask

  task automatic model_step(int k);
    int nxt;
    if (!enabled) begin
      m_owner[k] = -1;
      m_run[k] = 0;
    end else if (m_owner[k] < 0) begin
      nxt = pick(requests, -1, m_last[k]);
      if (nxt >= 0) begin
        m_owner[k] = nxt; m_last[k] = nxt; m_run[k] = 1;
      end
    end else begin
      nxt = pick(requests, m_owner[k], m_last[k]);
      if (requests[m_owner[k]] && !(m_run[k] >= m_hmax[k] && nxt >= 0)) begin
        m_run[k]++;
      end else if (nxt >= 0) begin
        m_owner[k] = nxt; m_last[k] = nxt; m_run[k] = 1;
      end else begin
        m_owner[k] = -1; m_run[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_grant(k) !== 16'h0000 || get_valid(k) !== 1'b0 || get_idx(k) !== 4'd0) begin
        errors++;
        $display("FAIL reset[%0d]: grant=%h valid=%b idx=%0d, required 0000/0/0",
                 k, get_grant(k), get_valid(k), get_idx(k));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    enabled = 1'b1;
  endtask

  task automatic test_single();
    requests = 16'h0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (grant8 !== 16'h0001 || idx8 !== 4'd0 || valid8 !== 1'b1) begin
        errors++;
        $display("FAIL single c%0d: grant=%h idx=%0d valid=%b, required 0001/0/1",
                 c, grant8, idx8, valid8);
      end
    end
  endtask

  task automatic test_alternate();
    logic [15:0] prev;
    int run, seg;
    prev = grant8; run = 0; seg = 0;
    requests = 16'h8001;
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if (grant8 !== 16'h0001 && grant8 !== 16'h8000) begin
        errors++;
        $display("FAIL alternate owner c%0d: grant=%h, required 0001 or 8000", c, grant8);
      end
      if (grant8 === prev) begin
        run++;
      end else begin
        if (seg >= 1) begin
          checks++;
          if (run != 8) begin
            errors++;
            $display("FAIL alternate hold: run=%0d, required 8", run);
          end
        end
        seg++; run = 1; prev = grant8;
      end
    end
  endtask

  task automatic test_release();
    requests = 16'h0000; tick();
    requests = 16'h0008; tick();
    checks++;
    if (idx8 !== 4'd3 || valid8 !== 1'b1) begin
      errors++;
      $display("FAIL release setup: idx=%0d valid=%b, required 3/1", idx8, valid8);
    end
    requests = 16'h0028; tick();
    requests = 16'h0020; tick();
    checks++;
    if (grant8 !== 16'h0020 || valid8 !== 1'b1) begin
      errors++;
      $display("FAIL release handover: grant=%h valid=%b, required 0020/1", grant8, valid8);
    end
  endtask

  task automatic test_enable();
    tick();
    enabled = 1'b0; tick();
    checks++;
    if (grant8 !== 16'h0000 || valid8 !== 1'b0 || grant1 !== 16'h0000) begin
      errors++;
      $display("FAIL disable: grant8=%h valid8=%b grant1=%h, required 0000/0/0000",
               grant8, valid8, grant1);
    end
    enabled = 1'b1; requests = 16'hFFFF; tick();
    checks++;
    if (idx8 !== 4'd6 || valid8 !== 1'b1) begin
      errors++;
      $display("FAIL reenable: idx=%0d valid=%b, required 6/1", idx8, valid8);
    end
  endtask

  task automatic test_rotate_h1();
    rst_n = 1'b0; model_reset(); #2; rst_n = 1'b1;
    requests = 16'hFFFF;
    for (int i = 0; i <= 16; i++) begin
      tick();
      checks++;
      if (idx1 !== 4'(i % 16) || valid1 !== 1'b1 || !$onehot(grant1)) begin
        errors++;
        $display("FAIL rotate_h1 step%0d: idx=%0d grant=%h, required idx %0d one-hot",
                 i, idx1, grant1, i % 16);
      end
    end
  endtask

  task automatic test_reset_mid();
    requests = 16'h0004; tick(); tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (grant8 !== 16'h0000 || grant1 !== 16'h0000 || valid8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: grant8=%h grant1=%h valid8=%b, required 0000/0000/0",
               grant8, grant1, valid8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    requests = 16'h0101;
    tick();
    checks++;
    if (idx8 !== 4'd0 || valid8 !== 1'b1 || idx1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_first: idx8=%0d valid8=%b idx1=%0d, required 0/1/0",
               idx8, valid8, idx1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enabled = ($urandom_range(0, 19) != 0);
      case ($urandom_range(0, 3))
        0: requests = 16'($urandom);
        1: requests = requests ^ (16'h0001 << $urandom_range(0, 15));
        default: requests = requests;
      endcase
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_grant(k) !== exp_grant(k) || get_valid(k) !== (m_owner[k] >= 0) ||
            (m_owner[k] >= 0 && get_idx(k) !== 4'(m_owner[k]))) begin
          errors++;
          $display("FAIL random[%0d] c%0d: grant=%h idx=%0d valid=%b, required grant=%h",
                   k, c, get_grant(k), get_idx(k), get_valid(k), exp_grant(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_release();
    test_enable();
    test_rotate_h1();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 Parameter HOLD_MAX, default 8, SHALL set the maximum consecutive grant cycles for one owner while another requester is active; legal range 1..16.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 enabled  input  1  arbitration enable.
REQ-005 requests  input  16  request vector; bit k is requester k; a request SHALL be held high until granted and no longer needed.
REQ-006 grant  output  16  one-hot grant, all-zero when no grant.
REQ-007 grant_idx  output  4  binary index of the current owner, valid only when grant_valid=1.
REQ-008 grant_valid  output  1  high while any grant bit is high.

Function
REQ-009 The block SHALL use two states: IDLE (no owner) and GRANT (owner = grant_idx).
REQ-010 Registered state SHALL be: state, grant_idx, pointer[3:0] (last owner) and hold_cnt[3:0].
REQ-011 Round-robin search SHALL scan requests starting at pointer+1 mod 16 and wrap to pointer; the first set bit wins.
REQ-012 IDLE -> GRANT when enabled=1 and requests!=0; the winner SHALL appear on grant/grant_idx on the next edge, giving one-cycle latency.
REQ-013 On each new grant, pointer SHALL be loaded with the winner index and hold_cnt SHALL be cleared to 0.
REQ-014 In GRANT with requests[grant_idx]=1, hold_cnt SHALL increment by 1 each cycle, saturating at HOLD_MAX-1.
REQ-015 Forced rotation: in GRANT, if hold_cnt==HOLD_MAX-1 and any other request bit is set, the next edge SHALL grant the round-robin winner among the other requesters.
REQ-016 If hold_cnt==HOLD_MAX-1 and no other request is set, the owner SHALL keep the grant indefinitely.
REQ-017 Release: in GRANT with requests[grant_idx]=0, the next edge SHALL grant the round-robin winner, with no idle bubble, or go to IDLE if requests==0.
REQ-018 The owner's own bit SHALL be excluded from the search at release or forced rotation, so no requester is granted twice in succession while another is waiting.
REQ-019 enabled=0 in any state SHALL force IDLE on the next edge and zero the outputs; pointer SHALL be retained.
REQ-020 grant SHALL equal the 4-to-16 decode of grant_idx gated by grant_valid, and SHALL be combinational from registers only, with no path from requests to grant.
REQ-021 grant_valid SHALL be 1 exactly when state==GRANT.
REQ-022 At most one grant bit SHALL be high in any cycle.
REQ-023 With HOLD_MAX=1 and multiple active requests, the grant SHALL rotate every cycle.
REQ-024 Fairness: any continuously asserted request SHALL be granted within 15*HOLD_MAX+1 cycles while enabled=1.

Reset
REQ-025 While rst_n=0, the block SHALL set state=IDLE, grant=16'h0000, grant_idx=0, grant_valid=0, pointer=4'hF and hold_cnt=0, independent of clk.
REQ-026 Reset asserted mid-grant SHALL drop grant within the same cycle.
REQ-027 After deassertion, the first search SHALL start at requester 0.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=0, GRANT=1), the requester count 16 and the index width 4.
REQ-029 The one-hot output SHALL be produced by one instance of the existing decoder_4x16, with inputs=grant_idx and enabled=grant_valid.
REQ-030 The round-robin search SHALL be implemented inside this module, not as a separate sub-module.

Verification
REQ-031 Scenario: reset, then requests=16'h0001 -> grant=16'h0001 and grant_idx=0 one cycle later, held while the request is held.
REQ-032 Scenario: requests=16'h8001 with both bits held and HOLD_MAX=8 -> grant alternates 0001/8000, each owner holding for 8 cycles.
REQ-033 Scenario: owner 3, requests change from 16'h0028 to 16'h0020 -> next edge grant=16'h0020 with no IDLE cycle.
REQ-034 Scenario: requests=16'hFFFF held, HOLD_MAX=1 -> grant_idx sequence 0,1,2,...,15,0; never two bits high at once.
REQ-035 Scenario: enabled dropped while owner is 5 -> grant=0 next cycle; on re-enable with requests=16'hFFFF, grant_idx=6.
REQ-036 Scenario: rst_n pulsed low mid-grant -> grant=0 immediately; after release with requests=16'h0101, grant_idx=0 first.
